bin2rns_32_31_21_5: RTL and testbench

Forward converter feeding the RNS2BIN_32_31_21_5 back-end. It takes a binary integer in the {32,31,21,5} dynamic range and returns its residues x0..x3 through an iterative end-around-fold datapath under valid/ready handshakes. The output widths match the reverse converter's residue inputs, so x0..x3 wire directly to it after the RNS arithmetic stage.

---
 rtl/bin2rns_32_31_21_5.sv | 133 +++++++++++++
 tb/tb_bin2rns_32_31_21_5.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bin2rns_32_31_21_5.sv
// Binary to RNS {32,31,21,5} forward converter: iterative end-around folding
// of three accumulators, then a small final correction, under valid/ready.
module bin2rns_32_31_21_5 #(
  parameter int DYN_SIZE = 17,
  parameter int M_PROD   = 104160,
  parameter int MAX_MOD  = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DYN_SIZE-1:0] n_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [MAX_MOD-1:0]  x0,
  output logic [MAX_MOD-1:0]  x1,
  output logic [MAX_MOD-1:0]  x2,
  output logic [MAX_MOD-1:0]  x3,
  output logic                out_err
);
  localparam int          C31   = (DYN_SIZE + 4) / 5;
  localparam int          C21   = (DYN_SIZE + 5) / 6;
  localparam int          C5    = (DYN_SIZE + 3) / 4;
  localparam logic [31:0] MPROD = 32'(M_PROD);

  typedef enum logic [1:0] {IDLE, FOLD, CORR, DONE} state_t;

  state_t                state_q;
  logic [4:0]            r32_q;
  logic [DYN_SIZE-1:0]   a31_q, a21_q, a5_q;
  logic                  err_q;
  logic [MAX_MOD-1:0]    x0_q, x1_q, x2_q, x3_q;
  logic                  out_valid_q, out_err_q;

  logic [DYN_SIZE-1:0]   a31_d, a21_d, a5_d;
  logic [C31*5-1:0]      a31_x;
  logic [C21*6-1:0]      a21_x;
  logic [C5*4-1:0]       a5_x;
  logic                  ok31, ok21, ok5;
  logic [4:0]            x1_d, x2_d;
  logic [2:0]            x3_d;
  logic [5:0]            t21;
  logic [3:0]            t5;

  // Chunk sums: 2^5, 2^6, 2^4 are each congruent to 1 modulo 31, 21, 5.
  always_comb begin
    a31_x = (C31*5)'(a31_q);
    a21_x = (C21*6)'(a21_q);
    a5_x  = (C5*4)'(a5_q);
    a31_d = '0;
    a21_d = '0;
    a5_d  = '0;
    for (int i = 0; i < C31; i++) a31_d = a31_d + DYN_SIZE'(a31_x[i*5 +: 5]);
    for (int i = 0; i < C21; i++) a21_d = a21_d + DYN_SIZE'(a21_x[i*6 +: 6]);
    for (int i = 0; i < C5;  i++) a5_d  = a5_d  + DYN_SIZE'(a5_x[i*4 +: 4]);
  end

  assign ok31 = a31_q < DYN_SIZE'(32);
  assign ok21 = a21_q < DYN_SIZE'(64);
  assign ok5  = a5_q  < DYN_SIZE'(16);

  // a21 can settle at 63 (e.g. n=63 never folds), which is also 0 mod 21.
  always_comb begin
    t21  = a21_q[5:0];
    t5   = a5_q[3:0];
    x1_d = (a31_q[4:0] == 5'd31) ? 5'd0 : a31_q[4:0];
    if (t21 >= 6'd63)      x2_d = 5'(t21 - 6'd63);
    else if (t21 >= 6'd42) x2_d = 5'(t21 - 6'd42);
    else if (t21 >= 6'd21) x2_d = 5'(t21 - 6'd21);
    else                   x2_d = 5'(t21);
    if (t5 >= 4'd15)       x3_d = 3'(t5 - 4'd15);
    else if (t5 >= 4'd10)  x3_d = 3'(t5 - 4'd10);
    else if (t5 >= 4'd5)   x3_d = 3'(t5 - 4'd5);
    else                   x3_d = 3'(t5);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      r32_q       <= '0;
      a31_q       <= '0;
      a21_q       <= '0;
      a5_q        <= '0;
      err_q       <= 1'b0;
      x0_q        <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      x3_q        <= '0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          r32_q   <= n_in[4:0];
          a31_q   <= n_in;
          a21_q   <= n_in;
          a5_q    <= n_in;
          err_q   <= 32'(n_in) >= MPROD;
          state_q <= FOLD;
        end
        FOLD: if (ok31 && ok21 && ok5) begin
          state_q <= CORR;
        end else begin
          if (!ok31) a31_q <= a31_d;
          if (!ok21) a21_q <= a21_d;
          if (!ok5)  a5_q  <= a5_d;
        end
        CORR: begin
          x0_q        <= MAX_MOD'(r32_q);
          x1_q        <= MAX_MOD'(x1_d);
          x2_q        <= MAX_MOD'(x2_d);
          x3_q        <= MAX_MOD'(x3_d);
          out_err_q   <= err_q;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_err   = out_err_q;
  assign x0        = x0_q;
  assign x1        = x1_q;
  assign x2        = x2_q;
  assign x3        = x3_q;
endmodule

// File: tb/tb_bin2rns_32_31_21_5.sv
// Directed + random bench for bin2rns_32_31_21_5: scoreboard of n mod m
// residues with CRT reconstruction of every in-range word.
module tb_bin2rns_32_31_21_5;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [16:0] n_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  x0, x1, x2, x3;
  logic        out_err;

  bin2rns_32_31_21_5 dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .n_in(n_in), .out_valid(out_valid), .out_ready(out_ready),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] n;
    logic [20:0] res;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   n_acc = 0;
  int   n_out = 0;

  function automatic exp_t model(input logic [16:0] n);
    exp_t e;
    int   v;
    v     = int'(n);
    e.n   = n;
    e.res = {5'(v % 32), 5'(v % 31), 5'(v % 21), 5'(v % 5), v >= 104160};
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: push on accept, pop and compare on output handshake.
  always @(negedge clk) begin
    if (reset) begin
      n_acc = n_acc - sbq.size();
      sbq.delete();
    end else begin
      if (in_valid && in_ready) begin
        sbq.push_back(model(n_in));
        n_acc++;
      end
      if (out_valid && out_ready) begin
        exp_t    e;
        longint  rec;
        n_out++;
        n_cmp++;
        if (sbq.size() == 0) begin
          n_mis++;
          $error("FAIL sb_underflow: observed output %0h expected none", {x0, x1, x2, x3, out_err});
        end else begin
          e = sbq.pop_front();
          assert ({x0, x1, x2, x3, out_err} === e.res) else begin
            n_mis++;
            $error("FAIL residues n=%0d: observed %0h expected %0h", e.n, {x0, x1, x2, x3, out_err}, e.res);
          end
          if (!e.res[0]) begin
            rec = (longint'(x0) * 22785 + longint'(x1) * 43680 +
                   longint'(x2) * 79360 + longint'(x3) * 62496) % 104160;
            n_cmp++;
            assert (rec === longint'(e.n)) else begin
              n_mis++;
              $error("FAIL crt n=%0d: observed %0d expected %0d", e.n, rec, e.n);
            end
          end
        end
      end
    end
  end

  task automatic send(input logic [16:0] n);
    int tmo = 0;
    n_in     = n;
    in_valid = 1'b1;
    while (!in_ready && tmo < 50) begin
      @(posedge clk); #1; tmo++;
    end
    if (tmo >= 50) chk("accept_timeout", 32'(tmo), 32'(0));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!out_valid && lat < 20);
    if (!out_valid) chk("out_timeout", 32'(lat), 32'(0));
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("in_ready_after_hs", 32'(in_ready), 32'(1));
    chk("valid_drop_after_hs", 32'(out_valid), 32'(0));
  endtask

  task automatic convert(input logic [16:0] n);
    int lat;
    send(n);
    wait_out(lat);
    chk("latency_range", 32'(lat >= 2 && lat <= 5), 32'(1));
    release_out();
  endtask

  logic [16:0] bnd [8] = '{17'd31, 17'd32, 17'd63, 17'd64, 17'd1023, 17'd1024, 17'd104159, 17'd131071};

  initial begin
    int lat;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'(1));
    chk("reset_out_valid", 32'(out_valid), 32'(0));
    chk("reset_outputs", 32'({x0, x1, x2, x3, out_err}), 32'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    // n=0: minimum latency with out_ready held high
    out_ready = 1'b1;
    send(17'd0);
    wait_out(lat);
    chk("lat_zero", 32'(lat), 32'(2));
    @(posedge clk); #1;
    chk("in_ready_after_zero", 32'(in_ready), 32'(1));
    out_ready = 1'b0;

    convert(17'd12345);
    convert(17'd104159);
    convert(17'd104160);
    convert(17'd63);

    // backpressure: outputs held, in_valid pulses ignored
    send(17'd31);
    wait_out(lat);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      n_in     = 17'd777;
      @(posedge clk); #1;
      chk("bp_hold", 32'({x0, x1, x2, x3, out_err, out_valid}), 32'({5'd31, 5'd0, 5'd10, 5'd1, 1'b0, 1'b1}));
      chk("bp_in_ready", 32'(in_ready), 32'(0));
    end
    in_valid = 1'b0;
    release_out();

    // reset two cycles after accepting 12345
    send(17'd12345);
    @(posedge clk); #1;
    reset = 1'b1;
    #2;
    chk("rst_mid_in_ready", 32'(in_ready), 32'(1));
    chk("rst_mid_out_valid", 32'(out_valid), 32'(0));
    chk("rst_mid_outputs", 32'({x0, x1, x2, x3, out_err}), 32'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) convert(bnd[i]);

    // random sweep with input gaps and output backpressure
    for (int i = 0; i < 1500; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      send(17'($urandom_range(0, 104159)));
      wait_out(lat);
      chk("sweep_latency", 32'(lat >= 2 && lat <= 5), 32'(1));
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      release_out();
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sbq.size()), 32'(0));
    chk("word_count", 32'(n_out), 32'(n_acc));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
